// File: rtl/stack_pkg.sv
// Shared types and default sizes for the operand stack: command encodings,
// refill FSM states and default DEPTH/WIDTH.
package stack_pkg;

  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSH  = 3'b001,
    OP_POP   = 3'b010,
    OP_BINOP = 3'b011,
    OP_UNOP  = 3'b100,
    OP_DUP   = 3'b101,
    OP_SWAP  = 3'b110,
    OP_RSVD  = 3'b111
  } stack_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } stack_state_t;

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous RAM holding the spilled stack entries below NOS.
// Read data appears one cycle after an enabled read; contents are never reset.
module stack_ram #(
  parameter  int WORDS = 30,
  parameter  int WIDTH = 32,
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/operand_stack.sv
// Operand stack with TOS/NOS cached in registers feeding the ALU and deeper
// entries spilled to stack_ram. DUP/SWAP are enabled by OPSTACK_DUPSWAP_EN.
//
// state | meaning
// IDLE  | accepting commands
// FILL  | refill read in flight, NOS loaded from RAM on exit
module operand_stack
  import stack_pkg::*;
#(
  parameter  int DEPTH     = DEFAULT_DEPTH,
  parameter  int WIDTH     = DEFAULT_WIDTH,
  localparam int DW        = $clog2(DEPTH + 1),
  localparam int RAM_WORDS = DEPTH - 2,
  localparam int AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  output logic             op_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  stack_state_t     state_q, state_d;
  logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  logic             ram_en, ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_rdata;
  logic [DW-1:0]    depth_m2, depth_m3;

  stack_op_t op;
  logic      is_push, is_pop, is_binop, is_unop, is_dup, is_swap;
  logic      is_empty, is_full, lt_two;

  assign op       = stack_op_t'(op_code);
  assign depth_m2 = depth_q - DW'(2);
  assign depth_m3 = depth_q - DW'(3);
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DW'(DEPTH));
  assign lt_two   = (depth_q < DW'(2));

  always_comb begin
    is_push  = (op == OP_PUSH);
    is_pop   = (op == OP_POP);
    is_binop = (op == OP_BINOP);
    is_unop  = (op == OP_UNOP);
`ifdef OPSTACK_DUPSWAP_EN
    is_dup   = (op == OP_DUP);
    is_swap  = (op == OP_SWAP);
`else
    is_dup   = 1'b0;
    is_swap  = 1'b0;
`endif
  end

  stack_ram #(
    .WORDS (RAM_WORDS),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (nos_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    tos_d    = tos_q;
    nos_d    = nos_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;

    // a new error in the same cycle overrides the clear below
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (is_push || is_dup) begin
            if (is_full) begin
              ovf_d = 1'b1;
            end else if (is_dup && is_empty) begin
              unf_d = 1'b1;
            end else begin
              if (!lt_two) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = AW'(depth_m2);
              end
              nos_d   = tos_q;
              tos_d   = is_dup ? tos_q : push_data;
              depth_d = depth_q + DW'(1);
            end
          end else if (is_pop || is_binop) begin
            if (is_pop ? is_empty : lt_two) begin
              unf_d = 1'b1;
            end else begin
              tos_d   = is_pop ? nos_q : alu_result;
              depth_d = depth_q - DW'(1);
              if (depth_q >= DW'(3)) begin
                ram_en   = 1'b1;
                ram_addr = AW'(depth_m3);
                state_d  = FILL;
              end
            end
          end else if (is_unop) begin
            if (is_empty) unf_d = 1'b1;
            else          tos_d = alu_result;
          end else if (is_swap) begin
            if (lt_two) begin
              unf_d = 1'b1;
            end else begin
              tos_d = nos_q;
              nos_d = tos_q;
            end
          end
        end
      end
      FILL: begin
        nos_d   = ram_rdata;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign op_ready  = (state_q == IDLE);
  assign operand_a = nos_q;
  assign operand_b = tos_q;
  assign depth     = depth_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
